rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
//  Shares the single V3023 RTC bus-cycle engine between NREQ requesters, e.g. timer init
//  programming, periodic time read and user edit. Each request is one transfer: address
//  phase, then data phase, either write or read.
//  Picks a winner round-robin, pulses the engine start, and drives the address/data byte
//  in the engine's Sent_A/Sent_D windows. Captures read data and returns a per-requester ack.
//  Sits between the requester FSMs and the bus-cycle engine that generates AD/CS/WR/RD.
// PARAMETERS
//  NREQ     3    number of requesters (2..8)
//  TIMEOUT  255  max cycles in BUSY awaiting cyc_fin before abort
//  TW       8    timeout counter width; requires TIMEOUT < 2**TW
// PORTS
//  Clock       in   1        system clock, rising edge
//  Reset       in   1        synchronous, active-high
//  req         in   NREQ     request per requester; level, held until ack
//  req_we      in   NREQ     1=write, 0=read; per requester
//  req_addr    in   8*NREQ   RTC register address; requester i uses bits [8i+7:8i]
//  req_wdata   in   8*NREQ   write data; packed like req_addr
//  ack         out  NREQ     one-cycle pulse to the served requester at transfer end
//  rdata       out  8        read data; valid while ack is high; held until next capture
//  err         out  1        high with ack when the transfer timed out
//  busy        out  1        high in every state except IDLE
//  cyc_start   out  1        one-cycle start pulse to the bus-cycle engine (its ciclo input)
//  cyc_wr      out  1        transfer direction to the engine; valid from START to DONE
//  cyc_sent_a  in   1        engine address-phase window
//  cyc_sent_d  in   1        engine data-phase window
//  cyc_fin     in   1        engine end of transfer
//  bus_out     out  8        byte driven onto the RTC AD bus
//  bus_oe      out  1        output enable for bus_out
//  bus_in      in   8        AD bus value, sampled on reads
// BEHAVIOUR
//  Reset: state=IDLE, last_gnt=NREQ-1 (requester 0 wins first), timer=0, rdata=0.
//   All outputs 0. Reset in any state, mid-transfer included, aborts silently (no ack).
//  FSM states: IDLE -> START -> BUSY -> DONE -> IDLE.
//  IDLE: if req!=0, select the first asserted index searching from last_gnt+1 with
//   wrap-around. Register gnt, we_q, addr_q and wdata_q from that requester's slice;
//   next state START. If req==0, stay in IDLE.
//  START: cyc_start=1 for exactly this cycle; timer<=0; next state BUSY.
//  BUSY: timer increments each cycle.
//   cyc_fin=1 -> DONE with err_q=0.
//   else timer==TIMEOUT-1 -> DONE with err_q=1.
//  DONE: ack[gnt]=1 and err=err_q for this cycle only; last_gnt<=gnt; next state IDLE.
//  Latency: req high in IDLE at cycle t -> cyc_start at t+1; cyc_fin at cycle f -> ack at f+1.
//  Bus drive: combinational, active only in BUSY.
//   cyc_sent_a=1: bus_out=addr_q, bus_oe=1.
//   cyc_sent_d=1 and we_q=1: bus_out=wdata_q, bus_oe=1.
//   cyc_sent_d=1 and we_q=0: bus_oe=0; rdata<=bus_in every such cycle (last sample kept).
//   Otherwise bus_out=0, bus_oe=0.
//  Simultaneous events:
//   cyc_sent_a and cyc_sent_d both high: the address phase wins.
//   cyc_fin together with cyc_sent_*: drive and capture still happen in that cycle, then DONE.
//   cyc_fin on the timeout cycle: no error.
//  cyc_sent_a, cyc_sent_d and cyc_fin are ignored outside BUSY.
//  Requester protocol:
//   req dropped mid-transfer: the transfer still completes and ack is still pulsed.
//   req still high in the IDLE cycle after its ack: treated as a new request. Round-robin
//   puts it last, so it cannot starve the others.
//  Payload is frozen at grant; requester inputs may change once cyc_start has been seen.
//  busy=1 in START, BUSY and DONE.
// TESTING
//  1 write: req[0], we=1, addr 0x41, wdata 0x25 -> cyc_start 1 cycle later; bus_out=0x41,
//    bus_oe=1 in Sent_A; 0x25 in Sent_D; ack[0] one cycle after cyc_fin; err=0.
//  2 read: req[1], we=0, addr 0x42; model drives bus_in=0x59 in Sent_D -> bus_oe=0 in the
//    data phase; rdata=0x59 with ack[1].
//  3 contention: req=3'b111 held, each requester drops req on its ack and re-raises it
//    next cycle -> grants 0,1,2,0,1,2; exactly one ack per transfer; no idle cycle
//    between DONE and the next START beyond IDLE.
//  4 timeout: engine never asserts cyc_fin -> ack and err=1 exactly TIMEOUT+1 cycles after
//    cyc_start; the next request is served normally with err=0.
//  5 reset mid-BUSY: Reset during Sent_D -> next cycle busy=0, bus_oe=0, no ack; then
//    req=3'b110 -> requester 1 is granted first.
//  6 overlap: cyc_sent_a and cyc_sent_d high together with addr_q=0x43, wdata_q=0x12 ->
//    bus_out=0x43; cyc_fin asserted with no preceding phases -> ack, rdata unchanged.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin sharing of the single RTC bus-cycle engine.
// Each granted request is one address+data transfer; the arbiter drives the
// AD byte in the engine's phase windows, captures read data and acks the requester.
module rtc_bus_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_we,
    input  logic [8*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          rdata,
    output logic                err,
    output logic                busy,
    output logic                cyc_start,
    output logic                cyc_wr,
    input  logic                cyc_sent_a,
    input  logic                cyc_sent_d,
    input  logic                cyc_fin,
    output logic [7:0]          bus_out,
    output logic                bus_oe,
    input  logic [7:0]          bus_in
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state, state_nx;
    logic [NREQ-1:0] gnt_oh, gnt_oh_nx;
    logic [GW-1:0]   gnt_idx, gnt_idx_nx;
    logic [GW-1:0]   last_gnt, last_gnt_nx;
    logic            we_q, we_nx;
    logic [7:0]      addr_q, addr_nx;
    logic [7:0]      wdata_q, wdata_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            err_q, err_q_nx;
    logic [7:0]      rdata_nx;
    logic [NREQ-1:0] ack_nx;
    logic            err_nx, busy_nx, cyc_start_nx, cyc_wr_nx;
    logic            capture_c;

    // Round-robin pick: lowest requester above last_gnt, else lowest overall
    logic [NREQ-1:0]           above_mask;
    logic [NREQ-1:0]           req_above;
    logic [NREQ-1:0]           pick_vec;
    logic [NREQ-1:0]           pick_oh;
    logic [GW-1:0][NREQ-1:0]   idx_bit_mask;
    logic [7:0][NREQ-1:0]      addr_col;
    logic [7:0][NREQ-1:0]      wdata_col;
    logic [GW-1:0]             sel_idx;
    logic [7:0]                sel_addr;
    logic [7:0]                sel_wdata;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign above_mask[g] = (GW'(g) > last_gnt);
        for (genvar b = 0; b < GW; b++) begin : g_idx
            assign idx_bit_mask[b][g] = 1'((g >> b) & 1);
        end
        for (genvar k = 0; k < 8; k++) begin : g_col
            assign addr_col[k][g]  = req_addr[8*g+k];
            assign wdata_col[k][g] = req_wdata[8*g+k];
        end
    end

    assign req_above = req & above_mask;
    assign pick_vec  = (|req_above) ? req_above : req;
    assign pick_oh   = pick_vec & (~pick_vec + NREQ'(1));

    for (genvar b = 0; b < GW; b++) begin : g_sel_idx
        assign sel_idx[b] = |(pick_oh & idx_bit_mask[b]);
    end
    for (genvar k = 0; k < 8; k++) begin : g_sel_byte
        assign sel_addr[k]  = |(pick_oh & addr_col[k]);
        assign sel_wdata[k] = |(pick_oh & wdata_col[k]);
    end

    // AD bus drive and read-capture enable, only meaningful while BUSY
    always_comb begin
        bus_out   = '0;
        bus_oe    = 1'b0;
        capture_c = 1'b0;
        if (state == S_BUSY) begin
            if (cyc_sent_a) begin
                bus_out = addr_q;
                bus_oe  = 1'b1;
            end else if (cyc_sent_d) begin
                if (we_q) begin
                    bus_out = wdata_q;
                    bus_oe  = 1'b1;
                end else begin
                    capture_c = 1'b1;
                end
            end
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_nx    = state;
        gnt_oh_nx   = gnt_oh;
        gnt_idx_nx  = gnt_idx;
        last_gnt_nx = last_gnt;
        we_nx       = we_q;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        timer_nx    = timer;
        err_q_nx    = err_q;
        rdata_nx    = rdata;

        case (state)
            S_IDLE: begin
                if (|req) begin
                    gnt_oh_nx  = pick_oh;
                    gnt_idx_nx = sel_idx;
                    we_nx      = |(pick_oh & req_we);
                    addr_nx    = sel_addr;
                    wdata_nx   = sel_wdata;
                    state_nx   = S_START;
                end
            end
            S_START: begin
                timer_nx = '0;
                state_nx = S_BUSY;
            end
            S_BUSY: begin
                timer_nx = timer + TW'(1);
                if (capture_c) begin
                    rdata_nx = bus_in;
                end
                if (cyc_fin) begin
                    err_q_nx = 1'b0;
                    state_nx = S_DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_q_nx = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                last_gnt_nx = gnt_idx;
                state_nx    = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        ack_nx       = (state_nx == S_DONE) ? gnt_oh_nx : '0;
        err_nx       = (state_nx == S_DONE) && err_q_nx;
        busy_nx      = (state_nx != S_IDLE);
        cyc_start_nx = (state_nx == S_START);
        cyc_wr_nx    = (state_nx != S_IDLE) && we_nx;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            gnt_oh    <= '0;
            gnt_idx   <= '0;
            last_gnt  <= GW'(NREQ - 1);
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            timer     <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cyc_start <= 1'b0;
            cyc_wr    <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt_oh    <= gnt_oh_nx;
            gnt_idx   <= gnt_idx_nx;
            last_gnt  <= last_gnt_nx;
            we_q      <= we_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            timer     <= timer_nx;
            err_q     <= err_q_nx;
            rdata     <= rdata_nx;
            ack       <= ack_nx;
            err       <= err_nx;
            busy      <= busy_nx;
            cyc_start <= cyc_start_nx;
            cyc_wr    <= cyc_wr_nx;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed vectors plus hand-written corner sequences.
module tb_rtc_bus_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned TW      = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [NREQ-1:0]   req, req_we;
    logic [8*NREQ-1:0] req_addr, req_wdata;
    logic [NREQ-1:0]   ack;
    logic [7:0]        rdata;
    logic              err, busy, cyc_start, cyc_wr;
    logic              cyc_sent_a, cyc_sent_d, cyc_fin;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic [7:0]        bus_in;

    rtc_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .busy       (busy),
        .cyc_start  (cyc_start),
        .cyc_wr     (cyc_wr),
        .cyc_sent_a (cyc_sent_a),
        .cyc_sent_d (cyc_sent_d),
        .cyc_fin    (cyc_fin),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .bus_in     (bus_in)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [NREQ-1:0] mask;
        int              g;
        logic            we;
        logic [7:0]      addr;
        logic [7:0]      wdata;
        logic [7:0]      bin;
        logic [7:0]      exp_rd;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;
    int   cnt;
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Requester g gets the payload; every other slice gets a decoy value
    task automatic set_payload(input int g, input logic we, input logic [7:0] a, input logic [7:0] d);
        logic [NREQ-1:0] sel;
        sel       = NREQ'(1) << g;
        req_we    = we ? sel : ~sel;
        req_addr  = {NREQ{a ^ 8'hFF}} ^ ((8*NREQ)'(8'hFF) << (8*g));
        req_wdata = {NREQ{d ^ 8'hFF}} ^ ((8*NREQ)'(8'hFF) << (8*g));
    endtask

    // One full transfer with a well-behaved engine: Sent_A, Sent_D, fin
    task automatic run_xfer(input int id, input vec_t t);
        logic [NREQ-1:0] exp_ack;
        exp_ack = NREQ'(1) << t.g;
        set_payload(t.g, t.we, t.addr, t.wdata);
        req = t.mask;
        tick();
        chk($sformatf("v%0d start", id), cyc_start, 1);
        chk($sformatf("v%0d cyc_wr", id), cyc_wr, t.we);
        req = '0;
        tick();
        cyc_sent_a = 1'b1;
        #1;
        chk($sformatf("v%0d start_once", id), cyc_start, 0);
        chk($sformatf("v%0d addr_bus", id), bus_out, t.addr);
        chk($sformatf("v%0d addr_oe", id), bus_oe, 1);
        tick();
        cyc_sent_a = 1'b0;
        cyc_sent_d = 1'b1;
        bus_in     = t.bin;
        #1;
        chk($sformatf("v%0d data_oe", id), bus_oe, t.we);
        if (t.we) chk($sformatf("v%0d data_bus", id), bus_out, t.wdata);
        tick();
        cyc_sent_d = 1'b0;
        bus_in     = 8'h00;
        cyc_fin    = 1'b1;
        tick();
        cyc_fin = 1'b0;
        chk($sformatf("v%0d ack", id), ack, exp_ack);
        chk($sformatf("v%0d err", id), err, 0);
        chk($sformatf("v%0d rdata", id), rdata, t.exp_rd);
        chk($sformatf("v%0d busy_done", id), busy, 1);
        tick();
        chk($sformatf("v%0d busy_idle", id), busy, 0);
        chk($sformatf("v%0d ack_clear", id), ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'b001, 0, 1'b1, 8'h41, 8'h25, 8'hC7, 8'h00};
        vecs[1] = '{3'b010, 1, 1'b0, 8'h42, 8'h00, 8'h59, 8'h59};
        vecs[2] = '{3'b110, 2, 1'b1, 8'h10, 8'h7E, 8'hC7, 8'h59};
        vecs[3] = '{3'b011, 0, 1'b0, 8'h05, 8'h00, 8'hA3, 8'hA3};
        vecs[4] = '{3'b101, 2, 1'b0, 8'h0F, 8'h00, 8'h3C, 8'h3C};
        vecs[5] = '{3'b111, 0, 1'b1, 8'h20, 8'h99, 8'hC7, 8'h3C};

        Reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        cyc_sent_a = 1'b0; cyc_sent_d = 1'b0; cyc_fin = 1'b0; bus_in = 8'h00;
        tick();
        tick();
        chk("rst ack", ack, 0);
        chk("rst rdata", rdata, 0);
        chk("rst err", err, 0);
        chk("rst busy", busy, 0);
        chk("rst cyc_start", cyc_start, 0);
        chk("rst cyc_wr", cyc_wr, 0);
        chk("rst bus_oe", bus_oe, 0);
        chk("rst bus_out", bus_out, 0);
        Reset = 1'b0;

        // Engine strobes outside BUSY must be ignored
        cyc_sent_a = 1'b1; cyc_fin = 1'b1;
        #1;
        chk("idle oe", bus_oe, 0);
        tick();
        cyc_sent_a = 1'b0; cyc_fin = 1'b0;
        chk("idle ack", ack, 0);
        chk("idle busy", busy, 0);

        for (int i = 0; i < 6; i++) run_xfer(i, vecs[i]);

        // Contention: all three held, each drops on its ack and re-raises next cycle
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req_we = '0; req_addr = 24'h030201; req_wdata = '0;
        req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            cnt = (n == 0) ? 0 : 1;
            do begin
                tick();
                cnt++;
            end while (!cyc_start && cnt < 12);
            chk($sformatf("cont%0d start_gap", n), cnt, (n == 0) ? 1 : 2);
            tick();
            cyc_fin = 1'b1;
            chk($sformatf("cont%0d early_ack", n), ack, 0);
            tick();
            cyc_fin = 1'b0;
            chk($sformatf("cont%0d ack", n), ack, NREQ'(1) << (n % 3));
            req = req & ~(NREQ'(1) << (n % 3));
            tick();
            chk($sformatf("cont%0d ack_once", n), ack, 0);
            req = (n < 5) ? 3'b111 : 3'b000;
        end
        tick();

        // Timeout: engine never finishes
        set_payload(0, 1'b1, 8'h30, 8'h31);
        req = 3'b001;
        tick();
        chk("to start", cyc_start, 1);
        req = '0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (ack == '0 && cnt < int'(TIMEOUT) + 20);
        chk("to latency", cnt, TIMEOUT + 1);
        chk("to err", err, 1);
        chk("to ack", ack, 3'b001);
        tick();
        chk("to err_clear", err, 0);
        chk("to busy", busy, 0);
        v = '{3'b010, 1, 1'b0, 8'h44, 8'h00, 8'h77, 8'h77};
        run_xfer(10, v);

        // Reset during a read data phase
        set_payload(2, 1'b0, 8'h45, 8'h00);
        req = 3'b100;
        tick();
        chk("rmid start", cyc_start, 1);
        req = '0;
        tick();
        cyc_sent_d = 1'b1;
        bus_in     = 8'hEE;
        Reset      = 1'b1;
        tick();
        chk("rmid busy", busy, 0);
        chk("rmid oe", bus_oe, 0);
        chk("rmid ack", ack, 0);
        chk("rmid rdata", rdata, 0);
        Reset      = 1'b0;
        cyc_sent_d = 1'b0;
        bus_in     = 8'h00;
        v = '{3'b110, 1, 1'b0, 8'h46, 8'h00, 8'h6A, 8'h6A};
        run_xfer(11, v);

        // Overlapping phase windows: address wins
        set_payload(0, 1'b1, 8'h43, 8'h12);
        req = 3'b001;
        tick();
        chk("ovl start", cyc_start, 1);
        req = '0;
        tick();
        cyc_sent_a = 1'b1; cyc_sent_d = 1'b1; bus_in = 8'hD5;
        #1;
        chk("ovl bus", bus_out, 8'h43);
        chk("ovl oe", bus_oe, 1);
        tick();
        cyc_sent_a = 1'b0; cyc_sent_d = 1'b0; bus_in = 8'h00; cyc_fin = 1'b1;
        tick();
        cyc_fin = 1'b0;
        chk("ovl ack", ack, 3'b001);
        chk("ovl rdata", rdata, 8'h6A);
        tick();

        // Read finished with no phases: rdata keeps its old value
        set_payload(1, 1'b0, 8'h47, 8'h00);
        req = 3'b010;
        tick();
        chk("fin start", cyc_start, 1);
        req = '0;
        tick();
        cyc_fin = 1'b1; bus_in = 8'hBB;
        tick();
        cyc_fin = 1'b0; bus_in = 8'h00;
        chk("fin ack", ack, 3'b010);
        chk("fin err", err, 0);
        chk("fin rdata", rdata, 8'h6A);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
